// File: rtl/seq_cpu_core_if.sv
// Bus between seq_cpu_core (master side) and its instruction memory / observer (slave side).
interface seq_cpu_core_if #(
   parameter int DATA_W   = 8,
   parameter int RF_DEPTH = 4,
   parameter int PC_W     = 5
) ();
   localparam int RA_W = $clog2(RF_DEPTH);

   logic [PC_W-1:0]   pc;
   logic [15:0]       instruction_wire;
   logic [2:0]        ALU_opcode_wire;
   logic [RA_W-1:0]   RF_addr;
   logic              RF_we;
   logic              A_re;
   logic [DATA_W-1:0] acc;
   logic              zero;
   logic              carry;
   logic              halted;
   logic              illegal;

   modport master (
      output pc, ALU_opcode_wire, RF_addr, RF_we, A_re, acc, zero, carry, halted, illegal,
      input  instruction_wire
   );

   modport slave (
      input  pc, ALU_opcode_wire, RF_addr, RF_we, A_re, acc, zero, carry, halted, illegal,
      output instruction_wire
   );
endinterface

// File: rtl/seq_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC/WB sequencer, register file, acc and flags.
// Define SEQ_CPU_CALL_EN to build CALL/RET with a one-deep link register.
module seq_cpu_core #(
   parameter int DATA_W   = 8,
   parameter int RF_DEPTH = 4,
   parameter int PC_W     = 5
) (
   input logic            clk,
   input logic            rst,
   seq_cpu_core_if.master bus
);
   localparam int RA_W = $clog2(RF_DEPTH);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;
   typedef enum logic [3:0] {
      OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_JMP, OP_JZ, OP_HALT, OP_CALL, OP_RET, OP_ILL_E, OP_ILL_F
   } op_e;

   state_e            state_q, state_d;
   logic [15:0]       ir_q;
   logic [PC_W-1:0]   pc_q, pc_d, pc_inc, target;
   logic [DATA_W-1:0] acc_q, res_q, res_d, imm, rd;
   logic              zero_q, carry_q, res_c_q, res_c_d, illegal_q;
   logic [DATA_W-1:0] rf_q [RF_DEPTH];
   logic [RA_W-1:0]   ra;
   op_e               op;
   logic              writes_a, is_illegal;
   logic              rf_we, a_re, halted;
   logic [2:0]        alu_op;
   logic [RA_W-1:0]   rf_addr;
   logic              unused_ir;

`ifdef SEQ_CPU_CALL_EN
   logic [PC_W-1:0]   link_q;
`endif

   assign op        = op_e'(ir_q[15:12]);
   assign ra        = ir_q[8 +: RA_W];
   assign imm       = DATA_W'(ir_q[7:0]);
   assign target    = PC_W'(ir_q[7:0]);
   assign rd        = rf_q[ra];
   assign pc_inc    = pc_q + PC_W'(1);
   assign unused_ir = ^ir_q;
   assign writes_a  = op inside {OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
`ifdef SEQ_CPU_CALL_EN
   assign is_illegal = op inside {OP_ILL_E, OP_ILL_F};
`else
   assign is_illegal = op inside {OP_CALL, OP_RET, OP_ILL_E, OP_ILL_F};
`endif

   // NOTE: sequential state uses <= so every register samples pre-edge values, regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = S_WB;
         S_WB:     state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      rf_we   = 1'b0;
      a_re    = 1'b0;
      alu_op  = 3'd0;
      rf_addr = '0;
      halted  = (state_q == S_HALT);
      if (state_q == S_EXEC || state_q == S_WB) begin
         rf_addr = ra;
         case (op)
            OP_ADD:  alu_op = 3'd0;
            OP_SUB:  alu_op = 3'd1;
            OP_AND:  alu_op = 3'd2;
            OP_OR:   alu_op = 3'd3;
            OP_XOR:  alu_op = 3'd4;
            default: alu_op = 3'd5;
         endcase
      end
      a_re  = (state_q == S_EXEC) && (op inside {OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
      rf_we = (state_q == S_WB) && (op == OP_ST);
   end

   // Logic ops, LD and LDI leave res_c_d at 0, which clears carry on writeback.
   always_comb begin
      res_d   = acc_q;
      res_c_d = 1'b0;
      case (op)
         OP_LDI:  res_d = imm;
         OP_LD:   res_d = rd;
         OP_ADD:  {res_c_d, res_d} = {1'b0, acc_q} + {1'b0, rd};
         OP_SUB:  {res_c_d, res_d} = {1'b0, acc_q} - {1'b0, rd};
         OP_AND:  res_d = acc_q & rd;
         OP_OR:   res_d = acc_q | rd;
         OP_XOR:  res_d = acc_q ^ rd;
         default: res_d = acc_q;
      endcase
   end

   always_comb begin
      pc_d = pc_inc;
      case (op)
         OP_JMP:  pc_d = target;
         OP_JZ:   pc_d = zero_q ? target : pc_inc;
`ifdef SEQ_CPU_CALL_EN
         OP_CALL: pc_d = target;
         OP_RET:  pc_d = link_q;
`endif
         default: pc_d = pc_inc;
      endcase
   end

   // NOTE: the register file sits in the reset branch because it must read as zero after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= '0;
         acc_q     <= '0;
         zero_q    <= 1'b1;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
         ir_q      <= '0;
         res_q     <= '0;
         res_c_q   <= 1'b0;
         for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
`ifdef SEQ_CPU_CALL_EN
         link_q    <= '0;
`endif
      end else begin
         if (state_q == S_DECODE) ir_q <= bus.instruction_wire;
         if (state_q == S_EXEC) begin
            res_q   <= res_d;
            res_c_q <= res_c_d;
         end
         if (state_q == S_WB) begin
            pc_q <= pc_d;
            if (writes_a) begin
               acc_q   <= res_q;
               zero_q  <= (res_q == '0);
               carry_q <= res_c_q;
            end
            if (op == OP_ST) rf_q[ra] <= acc_q;
            if (is_illegal) illegal_q <= 1'b1;
`ifdef SEQ_CPU_CALL_EN
            if (op == OP_CALL) link_q <= pc_inc;
`endif
         end
      end
   end

   assign bus.pc              = pc_q;
   assign bus.ALU_opcode_wire = alu_op;
   assign bus.RF_addr         = rf_addr;
   assign bus.RF_we           = rf_we;
   assign bus.A_re            = a_re;
   assign bus.acc             = acc_q;
   assign bus.zero            = zero_q;
   assign bus.carry           = carry_q;
   assign bus.halted          = halted;
   assign bus.illegal         = illegal_q;
endmodule

// File: tb/tb_seq_cpu_core.sv
// Bench for seq_cpu_core: instruction-level ISA model checked every cycle, plus directed programs.
module tb_seq_cpu_core;
   localparam int DATA_W   = 8;
   localparam int RF_DEPTH = 4;
   localparam int PC_W     = 5;
   localparam int RA_W     = $clog2(RF_DEPTH);
   localparam int DEPTH    = 1 << PC_W;
   localparam int MASK     = (1 << DATA_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_cpu_core_if #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH), .PC_W(PC_W)) ifc ();
   seq_cpu_core #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH), .PC_W(PC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   logic [15:0] mem [DEPTH];
   int  total = 0;
   int  bad   = 0;
   bit  check_en = 1'b0;
   int  we_cnt = 0;

   // Instruction memory: answers the address presented by the core.
   always @(negedge clk) ifc.instruction_wire = mem[ifc.pc];
   always @(negedge clk) if (ifc.RF_we === 1'b1) we_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int r, input int imm);
      return {4'(op), 4'(r), 8'(imm)};
   endfunction

   // Architectural model: one whole instruction retires every fourth non-reset edge.
   int m_pc, m_acc, m_zero, m_carry, m_ill, m_halt, m_link, m_phase;
   int m_rf [RF_DEPTH];

   task automatic exec_model();
      logic [15:0] ins;
      int op, r, imm, npc, v, c;
      bit wa;
      ins = mem[m_pc];
      op  = int'(ins[15:12]);
      r   = int'(ins[8 +: RA_W]);
      imm = int'(ins[7:0]);
      npc = (m_pc + 1) % DEPTH;
      wa  = 1'b1;
      c   = 0;
      v   = 0;
      case (op)
         1:       v = imm & MASK;
         2:       v = m_rf[r];
         4:       begin v = m_acc + m_rf[r]; c = (v > MASK) ? 1 : 0; v = v & MASK; end
         5:       begin c = (m_acc < m_rf[r]) ? 1 : 0; v = (m_acc - m_rf[r]) & MASK; end
         6:       v = m_acc & m_rf[r];
         7:       v = m_acc | m_rf[r];
         8:       v = m_acc ^ m_rf[r];
         default: wa = 1'b0;
      endcase
      case (op)
         3:  m_rf[r] = m_acc;
         9:  npc = imm % DEPTH;
         10: if (m_zero != 0) npc = imm % DEPTH;
         11: m_halt = 1;
`ifdef SEQ_CPU_CALL_EN
         12: begin m_link = npc; npc = imm % DEPTH; end
         13: npc = m_link;
`else
         12, 13: m_ill = 1;
`endif
         14, 15: m_ill = 1;
         default: ;
      endcase
      if (wa) begin
         m_acc   = v;
         m_zero  = (v == 0) ? 1 : 0;
         m_carry = c;
      end
      m_pc = npc;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 0; m_acc = 0; m_zero = 1; m_carry = 0;
         m_ill = 0; m_halt = 0; m_link = 0; m_phase = 0;
         foreach (m_rf[i]) m_rf[i] = 0;
      end else if (m_halt == 0) begin
         if (m_phase == 3) begin
            exec_model();
            m_phase = 0;
         end else begin
            m_phase++;
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [15:0] ins;
      int op;
      bit act;
      if (check_en) begin
         ins = mem[m_pc];
         op  = int'(ins[15:12]);
         act = (m_halt == 0) && (m_phase >= 2);
         check("pc",      ifc.pc,      m_pc);
         check("acc",     ifc.acc,     m_acc);
         check("zero",    ifc.zero,    m_zero);
         check("carry",   ifc.carry,   m_carry);
         check("illegal", ifc.illegal, m_ill);
         check("halted",  ifc.halted,  m_halt);
         check("A_re",    ifc.A_re,    act && m_phase == 2 && op >= 2 && op <= 8);
         check("RF_we",   ifc.RF_we,   act && m_phase == 3 && op == 3);
         check("ALU_op",  ifc.ALU_opcode_wire, !act ? 0 : (op >= 4 && op <= 8) ? op - 4 : 5);
         check("RF_addr", ifc.RF_addr, act ? int'(ins[8 +: RA_W]) : 0);
      end
   end

   task automatic load_clear();
      foreach (mem[i]) mem[i] = 16'h0000;
   endtask

   // Holds rst over one edge, checks reset values, releases rst at a falling edge.
   task automatic start();
      rst = 1'b1;
      @(negedge clk);
      check("rst_pc",      ifc.pc, 0);
      check("rst_acc",     ifc.acc, 0);
      check("rst_zero",    ifc.zero, 1);
      check("rst_carry",   ifc.carry, 0);
      check("rst_halted",  ifc.halted, 0);
      check("rst_illegal", ifc.illegal, 0);
      check("rst_strobes", {ifc.RF_we, ifc.A_re}, 0);
      check("rst_aluop",   ifc.ALU_opcode_wire, 0);
      check("rst_rfaddr",  ifc.RF_addr, 0);
      check_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_halt(input int budget);
      int n;
      n = 0;
      while (ifc.halted !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("halt_timeout", ifc.halted, 1);
   endtask

   int we_base;

   initial begin
      // LDI 0x05; HALT
      load_clear();
      mem[0] = enc(1, 0, 8'h05);
      mem[1] = enc(11, 0, 0);
      start();
      repeat (7) @(negedge clk);
      check("t1_not_yet_halted", ifc.halted, 0);
      @(negedge clk);
      check("t1_halted", ifc.halted, 1);
      check("t1_acc",    ifc.acc, 8'h05);
      check("t1_zero",   ifc.zero, 0);
      check("t1_pc",     ifc.pc, 2);

      // ADD carry-out, SUB borrow, single RF write
      load_clear();
      mem[0] = enc(1, 0, 8'hF0);
      mem[1] = enc(3, 1, 0);
      mem[2] = enc(1, 0, 8'h20);
      mem[3] = enc(4, 1, 0);
      mem[4] = enc(5, 1, 0);
      mem[5] = enc(11, 0, 0);
      we_base = we_cnt;
      start();
      repeat (16) @(negedge clk);
      check("t2_add_acc",   ifc.acc, 8'h10);
      check("t2_add_carry", ifc.carry, 1);
      wait_halt(100);
      check("t2_sub_acc",   ifc.acc, 8'h20);
      check("t2_sub_carry", ifc.carry, 1);
      check("t2_we_pulses", we_cnt - we_base, 1);

      // Countdown loop with JZ exit
      load_clear();
      mem[0] = enc(1, 0, 3);
      mem[1] = enc(3, 0, 0);
      mem[2] = enc(1, 0, 1);
      mem[3] = enc(3, 1, 0);
      mem[4] = enc(2, 0, 0);
      mem[5] = enc(5, 1, 0);
      mem[6] = enc(3, 0, 0);
      mem[7] = enc(10, 0, 9);
      mem[8] = enc(9, 0, 4);
      mem[9] = enc(11, 0, 0);
      start();
      wait_halt(300);
      check("t3_pc",    ifc.pc, 10);
      check("t3_acc",   ifc.acc, 0);
      check("t3_zero",  ifc.zero, 1);
      check("t3_carry", ifc.carry, 0);

      // Taken JZ to 30, NOP at 31 wraps to 0, untaken JZ falls through
      load_clear();
      mem[0]  = enc(10, 0, 30);
      mem[1]  = enc(11, 0, 0);
      mem[30] = enc(1, 0, 7);
      mem[31] = enc(0, 0, 0);
      start();
      repeat (4) @(negedge clk);
      check("t3w_jz_target", ifc.pc, 30);
      repeat (8) @(negedge clk);
      check("t3w_wrap", ifc.pc, 0);
      wait_halt(100);
      check("t3w_pc",  ifc.pc, 2);
      check("t3w_acc", ifc.acc, 7);

      // Illegal opcode 0xE: NOP plus sticky flag
      load_clear();
      mem[0] = enc(1, 0, 8'h42);
      mem[1] = enc(14, 0, 0);
      mem[2] = enc(1, 0, 8'h11);
      mem[3] = enc(11, 0, 0);
      start();
      repeat (8) @(negedge clk);
      check("t4_acc_kept", ifc.acc, 8'h42);
      check("t4_illegal",  ifc.illegal, 1);
      wait_halt(100);
      check("t4_acc_end",     ifc.acc, 8'h11);
      check("t4_illegal_end", ifc.illegal, 1);

      // rst during the WB of ST: no write lands, pc returns to 0
      load_clear();
      mem[0] = enc(1, 0, 8'h33);
      mem[1] = enc(3, 1, 0);
      mem[2] = enc(11, 0, 0);
      start();
      repeat (7) @(negedge clk);
      check("t5_in_st_wb", ifc.RF_we, 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_pc_after_rst", ifc.pc, 0);
      check("t5_we_after_rst", ifc.RF_we, 0);
      load_clear();
      mem[0] = enc(2, 1, 0);
      mem[1] = enc(11, 0, 0);
      start();
      wait_halt(100);
      check("t5_rf_clear", ifc.acc, 0);
      check("t5_zero",     ifc.zero, 1);

      // CALL 0x10 at pc 3, RET at 0x10
      load_clear();
      mem[3]     = enc(12, 0, 8'h10);
      mem[4]     = enc(11, 0, 0);
      mem[8'h10] = enc(13, 0, 0);
      start();
`ifdef SEQ_CPU_CALL_EN
      repeat (16) @(negedge clk);
      check("t6_call_target", ifc.pc, 8'h10);
      repeat (4) @(negedge clk);
      check("t6_ret_pc", ifc.pc, 4);
      wait_halt(100);
      check("t6_illegal", ifc.illegal, 0);
`else
      repeat (16) @(negedge clk);
      check("t6_fallthrough", ifc.pc, 4);
      check("t6_illegal", ifc.illegal, 1);
      wait_halt(100);
`endif
      check("t6_pc_end", ifc.pc, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
